// File: rtl/io_invert_test_sequencer_if.sv
// Pattern/result bundle between the IO inverter test sequencer and its
// surroundings: run control, datapath drive/observe, and the result registers.
interface io_invert_test_sequencer_if #(
    parameter int IN_WIDTH      = 13,
    parameter int OUT_WIDTH     = 14,
    parameter int IDX_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     start;
    logic                     abort;
    logic [IN_WIDTH-1:0]      pat_out;
    logic [OUT_WIDTH-1:0]     dut_in;
    logic [IDX_WIDTH-1:0]     pat_idx;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [IDX_WIDTH-1:0]     first_err_idx;
    logic [OUT_WIDTH-1:0]     first_err_bits;

    // Sequencer side
    modport master (
        input  start, abort, dut_in,
        output pat_out, pat_idx, busy, done, pass,
        output err_count, first_err_idx, first_err_bits
    );

    // Controller / datapath side
    modport slave (
        output start, abort, dut_in,
        input  pat_out, pat_idx, busy, done, pass,
        input  err_count, first_err_idx, first_err_bits
    );
endinterface

// File: rtl/io_invert_test_sequencer.sv
// Self-checking pattern sequencer for the IO inverter datapath.
// Walks a fixed pattern set (zeros, ones, walking one, walking zero, LFSR),
// drives each onto the datapath, waits a settle interval, and compares the
// datapath outputs against {1's, ~pattern}. Keeps a saturating error count
// and the index/bit-difference of the first failing pattern.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; outputs cleared or holding aborted results
// S_APPLY  | load pat_out with pattern(pat_idx), arm the settle counter
// S_SETTLE | let the datapath settle for SETTLE_CYCLES cycles
// S_CHECK  | compare dut_in to expected, update errors, advance or finish
// S_DONE   | run finished; done=1, results held until next start
module io_invert_test_sequencer #(
    parameter int IN_WIDTH      = 13,
    parameter int OUT_WIDTH     = 14,
    parameter int SETTLE_CYCLES = 2,
    parameter int LFSR_COUNT    = 16,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int IDX_WIDTH     = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    io_invert_test_sequencer_if.master bus
);

    localparam int TOTAL     = 2 + 2 * IN_WIDTH + LFSR_COUNT;
    localparam int WZ_BASE   = 2 + IN_WIDTH;
    localparam int LFSR_BASE = 2 + 2 * IN_WIDTH;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(TOTAL - 1);
    localparam logic [7:0]           SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [15:0]          LFSR_SEED   = 16'hACE1;
    localparam logic [15:0]          LFSR_TAPS   = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IN_WIDTH-1:0]      pat_out_q, pat_out_d;
    logic [IDX_WIDTH-1:0]     pat_idx_q, pat_idx_d;
    logic [7:0]               settle_cnt_q, settle_cnt_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_WIDTH-1:0]     first_idx_q, first_idx_d;
    logic [OUT_WIDTH-1:0]     first_bits_q, first_bits_d;

    logic [IN_WIDTH-1:0]      pattern;
    logic [31:0]              idx_ext;
    logic [OUT_WIDTH-1:0]     expected;
    logic [OUT_WIDTH-1:0]     mismatch;
    logic [15:0]              lfsr_next;
    logic                     err_sat;

    // Pattern generator: selects the pattern class from the current index
    always_comb begin
        idx_ext = 32'(pat_idx_q);
        pattern = '0;
        if (idx_ext == 32'd0) begin
            pattern = '0;
        end else if (idx_ext == 32'd1) begin
            pattern = '1;
        end else if (idx_ext < 32'(WZ_BASE)) begin
            pattern = IN_WIDTH'(1) << (idx_ext - 32'd2);
        end else if (idx_ext < 32'(LFSR_BASE)) begin
            pattern = ~(IN_WIDTH'(1) << (idx_ext - 32'(WZ_BASE)));
        end else begin
            pattern = lfsr_q[IN_WIDTH-1:0];
        end
    end

    // Upper output bits of a healthy datapath are tied high
    assign expected  = {{(OUT_WIDTH - IN_WIDTH){1'b1}}, ~pat_out_q};
    assign mismatch  = bus.dut_in ^ expected;
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign err_sat   = &err_cnt_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pat_out_q    <= '0;
            pat_idx_q    <= '0;
            settle_cnt_q <= '0;
            lfsr_q       <= LFSR_SEED;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_bits_q <= '0;
        end else begin
            state_q      <= state_d;
            pat_out_q    <= pat_out_d;
            pat_idx_q    <= pat_idx_d;
            settle_cnt_q <= settle_cnt_d;
            lfsr_q       <= lfsr_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_bits_q <= first_bits_d;
        end
    end

    // Next-state and register updates; abort overrides everything
    always_comb begin
        state_d      = state_q;
        pat_out_d    = pat_out_q;
        pat_idx_d    = pat_idx_q;
        settle_cnt_d = settle_cnt_q;
        lfsr_d       = lfsr_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        first_bits_d = first_bits_q;

        if (bus.abort) begin
            state_d   = S_IDLE;
            pat_out_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d      = S_APPLY;
                        pat_idx_d    = '0;
                        err_cnt_d    = '0;
                        first_idx_d  = '0;
                        first_bits_d = '0;
                        lfsr_d       = LFSR_SEED;
                    end
                end
                S_APPLY: begin
                    pat_out_d    = pattern;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch != '0) begin
                        if (!err_sat) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (err_cnt_q == '0) begin
                            first_idx_d  = pat_idx_q;
                            first_bits_d = mismatch;
                        end
                    end
                    // LFSR steps only after one of its own patterns was consumed
                    if (32'(pat_idx_q) >= 32'(LFSR_BASE)) begin
                        lfsr_d = lfsr_next;
                    end
                    if (pat_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        pat_idx_d = pat_idx_q + 1'b1;
                        state_d   = S_APPLY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.pat_out        = pat_out_q;
    assign bus.pat_idx        = pat_idx_q;
    assign bus.busy           = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = (state_q == S_DONE) && (err_cnt_q == '0);
    assign bus.err_count      = err_cnt_q;
    assign bus.first_err_idx  = first_idx_q;
    assign bus.first_err_bits = first_bits_q;

endmodule

// File: tb/tb_io_invert_test_sequencer.sv
// Bench for the IO inverter test sequencer. Instance 0 uses the default
// parameters; instance 1 has no settle wait, no LFSR patterns and a 4-bit
// error counter. A behavioural datapath model with stuck-at-0 fault masks
// feeds dut_in; expected patterns and run results are queued at start time
// and popped when the sequencer reaches each check cycle or finishes.
module tb_io_invert_test_sequencer;

    typedef struct {
        int          err;
        int          fidx;
        logic [13:0] fbits;
        logic        pass;
        logic [12:0] last_pat;
    } res_t;

    logic clk;
    logic rst_n;

    logic        start_v [2];
    logic        abort_v [2];
    logic [13:0] mask_v  [2];

    logic [12:0] pat_w   [2];
    logic [7:0]  idx_w   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        pass_w  [2];
    logic [7:0]  err_w   [2];
    logic [7:0]  fidx_w  [2];
    logic [13:0] fbits_w [2];

    int n_cmp;
    int n_bad;

    logic [12:0] pat_q [$];
    res_t        res_q [$];

    io_invert_test_sequencer_if #(.IN_WIDTH(13), .OUT_WIDTH(14), .IDX_WIDTH(8), .ERR_CNT_WIDTH(8)) if_a ();
    io_invert_test_sequencer_if #(.IN_WIDTH(13), .OUT_WIDTH(14), .IDX_WIDTH(8), .ERR_CNT_WIDTH(4)) if_b ();

    io_invert_test_sequencer #(
        .IN_WIDTH(13), .OUT_WIDTH(14), .SETTLE_CYCLES(2), .LFSR_COUNT(16),
        .ERR_CNT_WIDTH(8), .IDX_WIDTH(8)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.master)
    );

    io_invert_test_sequencer #(
        .IN_WIDTH(13), .OUT_WIDTH(14), .SETTLE_CYCLES(0), .LFSR_COUNT(0),
        .ERR_CNT_WIDTH(4), .IDX_WIDTH(8)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.master)
    );

    // Healthy inverter datapath with optional stuck-at-0 outputs
    assign if_a.start  = start_v[0];
    assign if_a.abort  = abort_v[0];
    assign if_a.dut_in = {1'b1, ~if_a.pat_out} & ~mask_v[0];
    assign if_b.start  = start_v[1];
    assign if_b.abort  = abort_v[1];
    assign if_b.dut_in = {1'b1, ~if_b.pat_out} & ~mask_v[1];

    assign pat_w[0]   = if_a.pat_out;
    assign idx_w[0]   = if_a.pat_idx;
    assign busy_w[0]  = if_a.busy;
    assign done_w[0]  = if_a.done;
    assign pass_w[0]  = if_a.pass;
    assign err_w[0]   = if_a.err_count;
    assign fidx_w[0]  = if_a.first_err_idx;
    assign fbits_w[0] = if_a.first_err_bits;
    assign pat_w[1]   = if_b.pat_out;
    assign idx_w[1]   = if_b.pat_idx;
    assign busy_w[1]  = if_b.busy;
    assign done_w[1]  = if_b.done;
    assign pass_w[1]  = if_b.pass;
    assign err_w[1]   = {4'b0000, if_b.err_count};
    assign fidx_w[1]  = if_b.first_err_idx;
    assign fbits_w[1] = if_b.first_err_bits;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [12:0] pat_of(input int k, input logic [15:0] l);
        logic [12:0] one;
        one = 13'd1;
        if (k == 0)  return 13'd0;
        if (k == 1)  return 13'h1FFF;
        if (k < 15)  return one << (k - 2);
        if (k < 28)  return ~(one << (k - 15));
        return l[12:0];
    endfunction

    // Expected results after the first n patterns have been checked
    function automatic res_t model(input int n, input logic [13:0] mask, input int err_max);
        res_t        r;
        logic [15:0] l;
        logic [12:0] p;
        logic [13:0] mm;
        r.err = 0; r.fidx = 0; r.fbits = '0; r.pass = 1'b0; r.last_pat = '0;
        l = 16'hACE1;
        for (int k = 0; k < n; k++) begin
            p = pat_of(k, l);
            if (k >= 28) l = lfsr_step(l);
            mm = {1'b1, ~p} & mask;
            if (mm != 14'd0) begin
                if (r.err == 0) begin
                    r.fidx  = k;
                    r.fbits = mm;
                end
                if (r.err < err_max) r.err++;
            end
            r.last_pat = p;
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic check_zero(input int s);
        check_val("rst_pat_out", 32'(pat_w[s]), 0);
        check_val("rst_pat_idx", 32'(idx_w[s]), 0);
        check_val("rst_busy", 32'(busy_w[s]), 0);
        check_val("rst_done", 32'(done_w[s]), 0);
        check_val("rst_pass", 32'(pass_w[s]), 0);
        check_val("rst_err", 32'(err_w[s]), 0);
        check_val("rst_fidx", 32'(fidx_w[s]), 0);
        check_val("rst_fbits", 32'(fbits_w[s]), 0);
    endtask

    // Full run: per-pattern checks at each CHECK cycle, results at DONE
    task automatic run_seq(input int s, input int lfsr_cnt, input int period,
                           input logic [13:0] mask, input int err_max, input int restart_k);
        int          total;
        logic [15:0] l;
        logic [12:0] p;
        res_t        r;
        total = 28 + lfsr_cnt;
        l = 16'hACE1;
        for (int k = 0; k < total; k++) begin
            pat_q.push_back(pat_of(k, l));
            if (k >= 28) l = lfsr_step(l);
        end
        res_q.push_back(model(total, mask, err_max));
        mask_v[s] = mask;

        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1 start_v[s] = 1'b0;
        repeat (period - 1) @(posedge clk);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            p = pat_q.pop_front();
            check_val("pat_out", 32'(pat_w[s]), 32'(p));
            check_val("pat_idx", 32'(idx_w[s]), k);
            check_val("busy", 32'(busy_w[s]), 1);
            if (k == 0) begin
                check_val("done_run", 32'(done_w[s]), 0);
                check_val("pass_run", 32'(pass_w[s]), 0);
            end
            if (k == restart_k) start_v[s] = 1'b1;
            @(posedge clk);
            #1 start_v[s] = 1'b0;
            if (k < total - 1) repeat (period - 1) @(posedge clk);
        end
        @(negedge clk);
        r = res_q.pop_front();
        check_val("done", 32'(done_w[s]), 1);
        check_val("busy_done", 32'(busy_w[s]), 0);
        check_val("pass", 32'(pass_w[s]), 32'(r.pass));
        check_val("err_count", 32'(err_w[s]), r.err);
        check_val("first_err_idx", 32'(fidx_w[s]), r.fidx);
        check_val("first_err_bits", 32'(fbits_w[s]), 32'(r.fbits));
        check_val("pat_out_hold", 32'(pat_w[s]), 32'(r.last_pat));
    endtask

    initial begin
        res_t r;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0;
            abort_v[s] = 1'b0;
            mask_v[s]  = '0;
        end
        #12;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal run with a start pulse while busy (ignored)
        run_seq(0, 16, 4, 14'h0000, 255, 12);
        // Bit 5 stuck at 0, including LFSR patterns
        run_seq(0, 16, 4, 14'h0020, 255, -1);
        // Start from DONE clears the previous failures
        run_seq(0, 16, 4, 14'h0000, 255, -1);

        // Abort during SETTLE of pattern 20 with bit 5 stuck
        mask_v[0] = 14'h0020;
        res_q.push_back(model(20, 14'h0020, 255));
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (81) @(posedge clk);
        @(negedge clk);
        check_val("abort_pre_busy", 32'(busy_w[0]), 1);
        check_val("abort_pre_idx", 32'(idx_w[0]), 20);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1 abort_v[0] = 1'b0;
        r = res_q.pop_front();
        check_val("abort_busy", 32'(busy_w[0]), 0);
        check_val("abort_done", 32'(done_w[0]), 0);
        check_val("abort_pass", 32'(pass_w[0]), 0);
        check_val("abort_pat_out", 32'(pat_w[0]), 0);
        check_val("abort_err", 32'(err_w[0]), r.err);
        check_val("abort_fidx", 32'(fidx_w[0]), r.fidx);
        check_val("abort_fbits", 32'(fbits_w[0]), 32'(r.fbits));
        repeat (3) @(posedge clk);
        #1 check_val("abort_idle_busy", 32'(busy_w[0]), 0);
        // Restart from idx 0 with a reseeded LFSR
        run_seq(0, 16, 4, 14'h0000, 255, -1);

        // Asynchronous reset in the middle of a CHECK cycle
        mask_v[0] = 14'h0020;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(0, 16, 4, 14'h0000, 255, -1);

        // No-settle instance: top bit stuck saturates the 4-bit counter
        run_seq(1, 0, 2, 14'h2000, 15, -1);
        run_seq(1, 0, 2, 14'h0000, 15, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
